// File: rtl/mips_regfile_sb.sv
// rtl/mips_regfile_sb.sv - MIPS register file with two read, two write ports and a busy scoreboard
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  input  logic                use1,
  input  logic                use2,
  output logic                busy1,
  output logic                busy2,
  output logic                stall,
  input  logic                iss_we,
  input  logic [ADDR_W-1:0]   iss_dst,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   wa0,
  input  logic [DATA_W-1:0]   wd0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   wa1,
  input  logic [DATA_W-1:0]   wd1,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_dout,
  output logic [ADDR_W:0]     busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [ADDR_W:0]   n_up;
  logic [ADDR_W:0]   n_down;

  // Register 0 is not storage when hardwired to zero.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  // Read mux: optional forwarding from the write ports (port 1 has priority),
  // then the array; register 0 always reads as zero when hardwired.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs_q[a];
`ifdef REGFILE_BYPASS_EN
    if (we1 && (wa1 == a)) begin
      v = wd1;
    end else if (we0 && (wa0 == a)) begin
      v = wd0;
    end
`endif
    if (!addr_valid(a)) begin
      v = '0;
    end
    return v;
  endfunction

  // Next-state of the array: port 0 first so port 1 overrides a same-address write.
  always_comb begin
    regs_d = regs_q;
    if (we0 && addr_valid(wa0)) begin
      regs_d[wa0] = wd0;
    end
    if (we1 && addr_valid(wa1)) begin
      regs_d[wa1] = wd1;
    end
  end

  // Scoreboard next-state (set beats clear) and the transition counts feeding busy_cnt.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    busy_d  = busy_q;
    n_up    = '0;
    n_down  = '0;
    for (int r = 0; r < NREG; r++) begin
      set_vec[r] = iss_we && (iss_dst == ADDR_W'(r)) && addr_valid(ADDR_W'(r));
      clr_vec[r] = (we0 && (wa0 == ADDR_W'(r))) || (we1 && (wa1 == ADDR_W'(r)));
      if (set_vec[r]) begin
        busy_d[r] = 1'b1;
        if (!busy_q[r]) begin
          n_up = n_up + (ADDR_W+1)'(1);
        end
      end else if (clr_vec[r]) begin
        busy_d[r] = 1'b0;
        if (busy_q[r]) begin
          n_down = n_down + (ADDR_W+1)'(1);
        end
      end
    end
    busy_cnt_d = busy_cnt_q + n_up - n_down;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Decode-side read data, busy flags and stall.
  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
`ifdef REGFILE_BYPASS_EN
    busy1 = busy_q[ra1] & ~clr_vec[ra1];
    busy2 = busy_q[ra2] & ~clr_vec[ra2];
`else
    busy1 = busy_q[ra1];
    busy2 = busy_q[ra2];
`endif
    stall    = (use1 & busy1) | (use2 & busy2);
    dbg_dout = addr_valid(dbg_addr) ? regs_q[dbg_addr] : '0;
    busy_cnt = busy_cnt_q;
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb/tb_mips_regfile_sb.sv - randomized self-checking bench for mips_regfile_sb
module tb_mips_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, iss_dst, wa0, wa1, dbg_addr;
  logic [31:0] rd1, rd2, wd0, wd1, dbg_dout;
  logic        use1, use2, busy1, busy2, stall, iss_we, we0, we1;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  int          c0;

  always #5 clk = ~clk;

  mips_regfile_sb dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .use1(use1), .use2(use2), .busy1(busy1), .busy2(busy2), .stall(stall),
    .iss_we(iss_we), .iss_dst(iss_dst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .dbg_addr(dbg_addr), .dbg_dout(dbg_dout), .busy_cnt(busy_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic bit m_writing(input logic [4:0] a);
    return (we0 && wa0 == a) || (we1 && wa1 == a);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && we1 && wa1 == a) return wd1;
    if (BYP && we0 && wa0 == a) return wd0;
    return m_reg[a];
  endfunction

  function automatic logic m_busy_rd(input logic [4:0] a);
    return m_busy[a] && !(BYP && m_writing(a));
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    iss_we = 0; we0 = 0; we1 = 0; use1 = 0; use2 = 0;
  endtask

  // Check combinational outputs against the model, clock once, advance the model.
  task automatic step();
    #1;
    chk("rd1", rd1, m_read(ra1));
    chk("rd2", rd2, m_read(ra2));
    chk("busy1", 32'(busy1), 32'(m_busy_rd(ra1)));
    chk("busy2", 32'(busy2), 32'(m_busy_rd(ra2)));
    chk("stall", 32'(stall), 32'((use1 && m_busy_rd(ra1)) || (use2 && m_busy_rd(ra2))));
    chk("dbg_dout", dbg_dout, (dbg_addr == 0) ? 32'h0 : m_reg[dbg_addr]);
    chk("busy_cnt", 32'(busy_cnt), 32'(m_count()));
    @(posedge clk);
    if (we0) m_busy[wa0] = 1'b0;
    if (we1) m_busy[wa1] = 1'b0;
    if (iss_we && iss_dst != 0) m_busy[iss_dst] = 1'b1;
    if (we0 && wa0 != 0) m_reg[wa0] = wd0;
    if (we1 && wa1 != 0) m_reg[wa1] = wd1;
    @(negedge clk);
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    ra1 = 5; ra2 = 0; iss_dst = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; dbg_addr = 5;
    m_reset();
    #12;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_cnt", 32'(busy_cnt), 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-cycle clears stored data and scoreboard immediately.
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; iss_we = 1; iss_dst = 5;
    step();
    idle();
    #1;
    chk("pre_rst_rd1", rd1, 32'hDEADBEEF);
    chk("pre_rst_cnt", 32'(busy_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_cnt", 32'(busy_cnt), 32'h0);
    chk("rst_dbg", dbg_dout, 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Register 0 ignores writes and issues.
    we0 = 1; wa0 = 0; wd0 = 32'h12345678; iss_we = 1; iss_dst = 0; ra1 = 0;
    step();
    idle();
    #1;
    chk("zero_rd1", rd1, 32'h0);
    chk("zero_cnt", 32'(busy_cnt), 32'h0);

    // Dual write to the same register: port 1 wins.
    we0 = 1; wa0 = 7; wd0 = 32'h1111; we1 = 1; wa1 = 7; wd1 = 32'h2222; ra2 = 7;
    #1;
    chk("dual_same_cycle", rd2, BYP ? 32'h2222 : 32'h0);
    step();
    idle();
    #1;
    chk("dual_next_cycle", rd2, 32'h2222);

    // Load-use stall on r3, released by a late writeback.
    iss_we = 1; iss_dst = 3;
    step();
    idle(); ra1 = 3; use1 = 1;
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_cnt", 32'(busy_cnt), 32'd1);
    step();
    step();
    we1 = 1; wa1 = 3; wd1 = 32'hCAFE;
    #1;
    chk("lu_wb_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
    if (BYP) chk("lu_wb_rd1", rd1, 32'hCAFE);
    step();
    we1 = 0;
    #1;
    chk("lu_after_stall", 32'(stall), 32'd0);
    chk("lu_after_rd1", rd1, 32'hCAFE);
    idle();

    // Set/clear race, then a double clear.
    iss_we = 1; iss_dst = 9;
    step();
    iss_dst = 10;
    step();
    idle();
    c0 = m_count();
    we0 = 1; wa0 = 9; wd0 = 32'h99; iss_we = 1; iss_dst = 9;
    step();
    idle();
    #1;
    chk("race_cnt", 32'(busy_cnt), 32'(c0));
    ra1 = 9; use1 = 1;
    #1;
    chk("race_busy", 32'(busy1), 32'd1);
    use1 = 0;
    we0 = 1; wa0 = 9; we1 = 1; wa1 = 10;
    step();
    idle();
    #1;
    chk("dbl_clear_cnt", 32'(busy_cnt), 32'(c0 - 2));

    // Fill every register, then drain two per cycle.
    for (int r = 1; r < 32; r++) begin
      iss_we = 1; iss_dst = 5'(r); ra1 = raddr(); ra2 = raddr();
      step();
    end
    idle();
    #1;
    chk("fill_cnt", 32'(busy_cnt), 32'd31);
    for (int r = 1; r < 32; r += 2) begin
      we0 = 1; wa0 = 5'(r); wd0 = $urandom; we1 = 1; wa1 = 5'(r + 1); wd1 = $urandom;
      step();
    end
    idle();
    #1;
    chk("drain_cnt", 32'(busy_cnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ra1 = raddr(); ra2 = raddr(); dbg_addr = raddr();
      use1 = 1'($urandom); use2 = 1'($urandom);
      iss_we = ($urandom_range(0, 2) != 0); iss_dst = raddr();
      we0 = 1'($urandom); wa0 = raddr(); wd0 = $urandom;
      we1 = ($urandom_range(0, 3) == 0); wa1 = raddr(); wd1 = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Parametrised next-generation MIPS register file for the pipelined CPU.
- Two read ports, two write ports (WB stage plus a late/long-latency writeback path) and a debug read port.
- Adds a per-register busy scoreboard: set when a producer issues, cleared on writeback, so decode can detect RAW/load-use stalls without comparing pipeline-stage addresses.
- Sits in ID (reads, stall detect) and WB (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  read data, port 1.
- rd2  out  DATA_W  read data, port 2.
- use1  in  1  decode actually uses ra1 (qualifies stall).
- use2  in  1  decode actually uses ra2 (qualifies stall).
- busy1  out  1  ra1 has an outstanding producer.
- busy2  out  1  ra2 has an outstanding producer.
- stall  out  1  (use1&busy1) | (use2&busy2).
- iss_we  in  1  an instruction with a destination issues this cycle.
- iss_dst  in  ADDR_W  destination of the issuing instruction.
- we0  in  1  write enable, port 0 (normal WB).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (late writeback, e.g. mult/div/load miss).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- dbg_addr  in  ADDR_W  debug/display read address.
- dbg_dout  out  DATA_W  debug read data; raw array value, never bypassed.
- busy_cnt  out  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Reset (async, active-high):
  - All registers = 0; all busy bits = 0; busy_cnt = 0.
  - Outputs follow combinationally: rd1 = rd2 = dbg_dout = 0; busy1 = busy2 = stall = 0.
  - Reset asserted mid-operation aborts any in-flight write; state is cleared immediately, not at the next edge.
- Register 0 (ZERO_REG=1):
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0 on every port.
  - iss_dst = 0 never sets busy; busy1/busy2 for address 0 are always 0.
- Writes: registers update at the rising edge.
  - we0 and we1 to the same address in the same cycle: port 1 wins (wd1 stored).
- Reads: combinational, 0-cycle latency.
  - With bypass (see Optional Feature), a read of an address being written this cycle returns the write data, applying the same port-1 priority.
- Scoreboard, per register r, next-state at the rising edge:
  - set   = iss_we & (iss_dst == r) & r valid.
  - clear = (we0 & wa0 == r) | (we1 & wa1 == r).
  - busy[r] <= set ? 1 : (clear ? 0 : busy[r]). Set wins over clear: a new producer issued in the same cycle as the old one retires.
  - Writes to a non-busy register are legal; the data is stored and busy is unaffected.
- busy1/busy2 (combinational):
  - busy1 = busy[ra1] & ~clear(ra1); busy2 likewise for ra2. A writeback in the current cycle releases the stall in that same cycle (requires bypass for correct data).
  - Issue this cycle does not affect busy1/busy2 until the next cycle.
- busy_cnt:
  - Registered; equals the population count of busy after each edge.
  - Range 0..NREG-1 with ZERO_REG=1, 0..NREG otherwise.
  - Updated incrementally: +1 per 0->1 transition, -1 per 1->0 transition; up to 1 set and 2 clears per cycle, so the net change is in -2..+1.
- dbg_dout: combinational raw array read; 0 for address 0 when ZERO_REG=1.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding on rd1/rd2 as described above; busy1/busy2 are masked by same-cycle clear.
- Undefined:
  - rd1/rd2 return array contents only; a same-cycle write becomes visible the cycle after.
  - busy1/busy2 = busy[ra] unmasked, so the stall holds one extra cycle through writeback.
  - Scoreboard and busy_cnt behaviour are otherwise unchanged.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst mid-cycle -> rd1 (ra1=5) = 0 immediately; busy_cnt = 0; dbg_dout = 0.
- Zero reg: we0=1, wa0=0, wd0=0x12345678 and iss_we=1, iss_dst=0 -> rd1 (ra1=0) = 0; busy_cnt stays 0.
- Dual write conflict: we0 (r7, 0x1111) and we1 (r7, 0x2222) in the same cycle -> next cycle rd2 = 0x2222.
  - With bypass, rd2 = 0x2222 also in the same cycle.
- Load-use stall: issue r3 at cycle N; decode at N+1 with ra1=3, use1=1 -> stall=1; busy_cnt=1.
  - we1 r3=0xCAFE at N+3 -> with bypass: stall=0 and rd1=0xCAFE at N+3; without bypass: stall=0 at N+4.
- Set/clear race: r9 busy; same cycle we0 r9 and iss_dst=9 -> r9 stays busy; busy_cnt unchanged.
  - Then clear r9 and r10 via we0 and we1 together -> busy_cnt decreases by 2.
- Fill: issue r1..r31 on consecutive cycles -> busy_cnt = 31; clear all -> busy_cnt = 0, no wrap.
